// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-select type and pipeline controller FSM states.
package cpu_types_pkg;

  // Register-select width used by the datapath register file.
  localparam int REGBITS = 5;

  typedef logic [REGBITS-1:0] regbits_t;

  // Sequencer states: normal flow, waiting on data, waiting on fetch, halted.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    IWAIT  = 2'd2,
    HALTED = 2'd3
  } ctrl_state_t;

  // A load in execute whose destination feeds a decode-stage source forces a
  // one-cycle bubble; register zero never carries a dependency.
  function automatic logic load_use(input logic ex_dren, input regbits_t ex_wsel,
                                    input regbits_t id_rs, input regbits_t id_rt);
    return ex_dren && (ex_wsel != '0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector between execute and decode stages.
module hazard_detect
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             i_ex_dREN,
  input  logic [REG_W-1:0] i_ex_wsel,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  output logic             o_lu_hazard
);

  logic w_wsel_nonzero;
  logic w_rs_match;
  logic w_rt_match;

  // Compare the execute-stage destination against both decode sources.
  always_comb begin
    w_wsel_nonzero = (i_ex_wsel != '0);
    w_rs_match     = (i_ex_wsel == i_id_rs);
    w_rt_match     = (i_ex_wsel == i_id_rt);
    o_lu_hazard    = i_ex_dREN & w_wsel_nonzero & (w_rs_match | w_rt_match);
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: latch enables/flushes, PC enable, memory wait FSM,
// halt, and stall/flush performance counters.
module pipeline_controller
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_redirect,
  input  logic             wb_halt,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             pc_en,
  output logic             fl_en,
  output logic             dl_en,
  output logic             el_en,
  output logic             ml_en,
  output logic             fl_flush,
  output logic             dl_flush,
  output logic             el_flush,
  output logic             ml_flush,
  output logic             dmem_suppress,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  ctrl_state_t      r_state;
  logic             r_halt;
  logic             r_dmem_suppress;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  logic w_memop;
  logic w_lu_hazard;
  logic w_advance;
  logic w_pc_en;
  logic w_fl_en, w_dl_en, w_el_en, w_ml_en;
  logic w_fl_flush, w_dl_flush, w_el_flush, w_ml_flush;

  assign w_memop = mem_dREN | mem_dWEN;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .i_ex_dREN  (ex_dREN),
    .i_ex_wsel  (ex_wsel),
    .i_id_rs    (id_rs),
    .i_id_rt    (id_rt),
    .o_lu_hazard(w_lu_hazard)
  );

  // Decide whether the memory stage (and everything behind it) may move this cycle.
  always_comb begin
    w_advance = 1'b0;
    unique case (r_state)
      RUN:     w_advance = ihit & (~w_memop | dhit);
      DWAIT:   w_advance = dhit & ihit;
      IWAIT:   w_advance = ihit;
      HALTED:  w_advance = 1'b0;
      default: w_advance = 1'b0;
    endcase
  end

  // Latch enables and flushes: redirect beats load-use, which beats normal flow.
  always_comb begin
    w_pc_en    = 1'b0;
    w_fl_en    = 1'b0;
    w_dl_en    = 1'b0;
    w_el_en    = 1'b0;
    w_ml_en    = 1'b0;
    w_fl_flush = 1'b0;
    w_dl_flush = 1'b0;
    w_el_flush = 1'b0;
    w_ml_flush = 1'b0;
    if (w_advance) begin
      if (mem_redirect) begin
        // Everything younger than the redirecting instruction is discarded,
        // so a pending load-use dependency no longer matters.
        w_pc_en    = 1'b1;
        w_fl_en    = 1'b1;
        w_dl_en    = 1'b1;
        w_el_en    = 1'b1;
        w_ml_en    = 1'b1;
        w_fl_flush = 1'b1;
        w_dl_flush = 1'b1;
        w_el_flush = 1'b1;
      end else if (w_lu_hazard) begin
        // Hold fetch/decode, push a bubble into execute, let memory drain.
        w_el_en    = 1'b1;
        w_el_flush = 1'b1;
        w_ml_en    = 1'b1;
      end else begin
        w_pc_en = 1'b1;
        w_fl_en = 1'b1;
        w_dl_en = 1'b1;
        w_el_en = 1'b1;
        w_ml_en = 1'b1;
      end
    end
  end

  // Memory wait / halt FSM with registered halt and data-request suppress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state         <= RUN;
      r_halt          <= 1'b0;
      r_dmem_suppress <= 1'b0;
    end else if (wb_halt) begin
      r_state         <= HALTED;
      r_halt          <= 1'b1;
      r_dmem_suppress <= 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_memop && !dhit) begin
            r_state         <= DWAIT;
            r_dmem_suppress <= 1'b0;
          end else if (w_memop && dhit && !ihit) begin
            // Data already returned: block reissue while fetch catches up.
            r_state         <= IWAIT;
            r_dmem_suppress <= 1'b1;
          end
        end
        DWAIT: begin
          if (dhit && ihit) begin
            r_state         <= RUN;
            r_dmem_suppress <= 1'b0;
          end else if (dhit && !ihit) begin
            r_state         <= IWAIT;
            r_dmem_suppress <= 1'b1;
          end
        end
        IWAIT: begin
          if (ihit) begin
            r_state         <= RUN;
            r_dmem_suppress <= 1'b0;
          end
        end
        HALTED: begin
          r_state         <= HALTED;
          r_halt          <= 1'b1;
          r_dmem_suppress <= 1'b1;
        end
        default: begin
          r_state         <= RUN;
          r_halt          <= 1'b0;
          r_dmem_suppress <= 1'b0;
        end
      endcase
    end
  end

  // Count cycles where the PC is held while the core is still live.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cycles <= '0;
    end else if ((r_state != HALTED) && !w_pc_en) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // Count redirect flushes actually taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_flush_events <= '0;
    end else if (w_advance && mem_redirect) begin
      r_flush_events <= r_flush_events + 1'b1;
    end
  end

  assign pc_en         = w_pc_en;
  assign fl_en         = w_fl_en;
  assign dl_en         = w_dl_en;
  assign el_en         = w_el_en;
  assign ml_en         = w_ml_en;
  assign fl_flush      = w_fl_flush;
  assign dl_flush      = w_dl_flush;
  assign el_flush      = w_el_flush;
  assign ml_flush      = w_ml_flush;
  assign dmem_suppress = r_dmem_suppress;
  assign halt          = r_halt;
  assign stall_cycles  = r_stall_cycles;
  assign flush_events  = r_flush_events;

endmodule
